zs_thin_engine: RTL

- Zhang-Suen thinning controller; sits directly downstream of the N×N image RAM and drives both of its ports.
- Operates in place on a binary image held in the RAM:
  - reads each centre pixel through the RAM primary port;
  - reads its 8 neighbours one per cycle through the dual read port;
  - marks deletable pixels, then sweeps the marked pixels to background;
  - alternates sub-iterations until an iteration deletes nothing.
- Done flag and iteration count go to the top-level controller.

---
 rtl/zs_thin_engine_if.sv | 31 +++
 rtl/zs_thin_engine.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/zs_thin_engine_if.sv
// rtl/zs_thin_engine_if.sv - RAM access bus between the thinning engine and the image RAM
//
// Purpose: bundles both RAM ports that the engine drives.
// Signals:
//   ram_we       write enable (held 2 cycles per write)
//   ram_addr     primary address (centre read / write)
//   ram_rd_addr  dual read address (neighbour reads)
//   ram_wdata    write data
//   ram_pdata    combinational read of ram_addr
//   ram_ddata    combinational read of ram_rd_addr
// Modports: master = engine, slave = RAM.
interface zs_thin_engine_if #(
  parameter int AW = 7
);
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [AW-1:0] ram_rd_addr;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_pdata;
  logic [7:0]    ram_ddata;

  modport master (
    output ram_we, ram_addr, ram_rd_addr, ram_wdata,
    input  ram_pdata, ram_ddata
  );

  modport slave (
    input  ram_we, ram_addr, ram_rd_addr, ram_wdata,
    output ram_pdata, ram_ddata
  );
endinterface

// File: rtl/zs_thin_engine.sv
// rtl/zs_thin_engine.sv - in-place Zhang-Suen thinning controller for an NxN image RAM
//
// Purpose: scans interior pixels, marks deletable ones (bit7), sweeps marks to
// background, alternating sub-iterations until a full iteration deletes nothing
// or MAX_ITER iterations have run.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle start pulse, accepted only in IDLE
//   busy         high while a run is in progress
//   done         completion level, cleared by the next accepted start
//   limit_hit    run stopped by MAX_ITER
//   iter_count   full iterations completed
//   ram          RAM bus (master side)
module zs_thin_engine #(
  parameter int N        = 8,
  parameter int bitSize  = 6,
  parameter int MAX_ITER = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              limit_hit,
  output logic [7:0]        iter_count,
  zs_thin_engine_if.master  ram
);

  localparam int AW = bitSize + 1;

  typedef enum logic [3:0] {
    IDLE, CENTER, NBR, DECIDE, MARK_WR, NEXT, SWEEP, SWEEP_WR, SUB_END, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] row_q, col_q, sweep_q;
  logic [2:0]    nbr_q;
  logic [7:0]    nb_q;        // nb_q[k] = neighbour P(k+2)
  logic [7:0]    centre_q;
  logic          wr_ph_q;     // second cycle of a two-cycle write
  logic          sub2_q;
  logic          sub1_del_q;
  logic [15:0]   del_q;
  logic          done_q, limit_q;
  logic [7:0]    iter_q;

  logic          we_c;
  logic [AW-1:0] addr_c, rd_addr_c;
  logic [7:0]    wdata_c;

  logic [AW-1:0] pix_addr, nbr_addr;
  logic [3:0]    b_cnt, a_cnt;
  logic          del_ok, last_pix, last_addr, hit, none_deleted;
  logic [7:0]    iter_next;

  assign pix_addr = AW'(row_q * N + col_q);

  always_comb begin
    case (nbr_q)
      3'd0:    nbr_addr = pix_addr - AW'(N);
      3'd1:    nbr_addr = pix_addr - AW'(N - 1);
      3'd2:    nbr_addr = pix_addr + AW'(1);
      3'd3:    nbr_addr = pix_addr + AW'(N + 1);
      3'd4:    nbr_addr = pix_addr + AW'(N);
      3'd5:    nbr_addr = pix_addr + AW'(N - 1);
      3'd6:    nbr_addr = pix_addr - AW'(1);
      default: nbr_addr = pix_addr - AW'(N + 1);
    endcase
  end

  // B = foreground neighbours, A = 0->1 transitions around the ring P2..P9,P2
  always_comb begin
    b_cnt = '0;
    a_cnt = '0;
    for (int i = 0; i < 8; i++) begin
      b_cnt = b_cnt + 4'(nb_q[i]);
      if (!nb_q[i] && nb_q[(i + 1) % 8]) a_cnt = a_cnt + 4'd1;
    end
  end

  always_comb begin
    del_ok = (b_cnt >= 4'd2) && (b_cnt <= 4'd6) && (a_cnt == 4'd1);
    if (sub2_q) del_ok = del_ok && !(nb_q[0] & nb_q[2] & nb_q[6]) && !(nb_q[0] & nb_q[4] & nb_q[6]);
    else        del_ok = del_ok && !(nb_q[0] & nb_q[2] & nb_q[4]) && !(nb_q[2] & nb_q[4] & nb_q[6]);
  end

  assign last_pix     = (row_q == AW'(N - 2)) && (col_q == AW'(N - 2));
  assign last_addr    = (sweep_q == AW'(N * N - 1));
  assign iter_next    = iter_q + 8'd1;
  assign hit          = (iter_next == 8'(MAX_ITER));
  assign none_deleted = !sub1_del_q && (del_q == 16'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    we_c      = 1'b0;
    addr_c    = '0;
    rd_addr_c = '0;
    wdata_c   = '0;
    case (state_q)
      IDLE:   if (start) state_d = CENTER;
      CENTER: begin
        addr_c  = pix_addr;
        state_d = (ram.ram_pdata == 8'h00) ? NEXT : NBR;
      end
      NBR: begin
        addr_c    = pix_addr;
        rd_addr_c = nbr_addr;
        if (nbr_q == 3'd7) state_d = DECIDE;
      end
      DECIDE: begin
        addr_c  = pix_addr;
        state_d = del_ok ? MARK_WR : NEXT;
      end
      MARK_WR: begin
        addr_c  = pix_addr;
        we_c    = 1'b1;
        wdata_c = centre_q | 8'h80;
        if (wr_ph_q) state_d = NEXT;
      end
      NEXT: begin
        addr_c = pix_addr;
        if (last_pix) state_d = (del_q != 16'd0) ? SWEEP : SUB_END;
        else          state_d = CENTER;
      end
      SWEEP: begin
        addr_c = sweep_q;
        if (ram.ram_pdata[7]) state_d = SWEEP_WR;
        else if (last_addr)   state_d = SUB_END;
      end
      SWEEP_WR: begin
        addr_c = sweep_q;
        we_c   = 1'b1;
        if (wr_ph_q) state_d = last_addr ? SUB_END : SWEEP;
      end
      SUB_END: begin
        if (!sub2_q)           state_d = CENTER;
        else if (none_deleted) state_d = DONE;
        else if (hit)          state_d = DONE;
        else                   state_d = CENTER;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q      <= '0;
      col_q      <= '0;
      sweep_q    <= '0;
      nbr_q      <= '0;
      nb_q       <= '0;
      centre_q   <= '0;
      wr_ph_q    <= 1'b0;
      sub2_q     <= 1'b0;
      sub1_del_q <= 1'b0;
      del_q      <= '0;
      done_q     <= 1'b0;
      limit_q    <= 1'b0;
      iter_q     <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          iter_q     <= '0;
          done_q     <= 1'b0;
          limit_q    <= 1'b0;
          del_q      <= '0;
          sub2_q     <= 1'b0;
          sub1_del_q <= 1'b0;
          row_q      <= AW'(1);
          col_q      <= AW'(1);
        end
        CENTER: begin
          centre_q <= ram.ram_pdata;
          nbr_q    <= '0;
        end
        NBR: begin
          nb_q[nbr_q] <= (ram.ram_ddata != 8'h00);
          nbr_q       <= nbr_q + 3'd1;
        end
        MARK_WR: begin
          wr_ph_q <= ~wr_ph_q;
          if (wr_ph_q) del_q <= del_q + 16'd1;
        end
        NEXT: begin
          if (last_pix) sweep_q <= '0;
          else if (col_q == AW'(N - 2)) begin
            row_q <= row_q + AW'(1);
            col_q <= AW'(1);
          end else col_q <= col_q + AW'(1);
        end
        SWEEP: if (!ram.ram_pdata[7] && !last_addr) sweep_q <= sweep_q + AW'(1);
        SWEEP_WR: begin
          wr_ph_q <= ~wr_ph_q;
          if (wr_ph_q && !last_addr) sweep_q <= sweep_q + AW'(1);
        end
        SUB_END: begin
          row_q <= AW'(1);
          col_q <= AW'(1);
          del_q <= '0;
          if (!sub2_q) begin
            sub1_del_q <= (del_q != 16'd0);
            sub2_q     <= 1'b1;
          end else begin
            iter_q <= iter_next;
            sub2_q <= 1'b0;
            if (none_deleted) done_q <= 1'b1;
            else if (hit) begin
              done_q  <= 1'b1;
              limit_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy            = (state_q != IDLE) && (state_q != DONE);
  assign done            = done_q;
  assign limit_hit       = limit_q;
  assign iter_count      = iter_q;
  assign ram.ram_we      = we_c;
  assign ram.ram_addr    = addr_c;
  assign ram.ram_rd_addr = rd_addr_c;
  assign ram.ram_wdata   = wdata_c;

endmodule
